csa_seq_multiplier: RTL
=======================

// Module: csa_seq_multiplier
// PURPOSE
//   Parametrised iterative carry-save multiplier, the sequential successor to
//   our fixed 4x4 combinational CSA array. Each cycle it adds one partial-product
//   row into a carry-save accumulator, then does one carry-propagate cycle.
//   Supports unsigned and two's-complement operands. Uses a valid/ready
//   handshake on the input and output sides. Sits between operand staging
//   and result consumers in the arithmetic datapath.
// PARAMETERS
//   WIDTH   4   operand width in bits (>=2); result is 2*WIDTH bits
// PORTS
//   clk         in   1         rising-edge clock
//   rst         in   1         synchronous, active-high reset
//   in_valid    in   1         operands a, b and signed_mode are valid
//   in_ready    out  1         block can accept operands (high only in IDLE)
//   a           in   WIDTH     multiplicand
//   b           in   WIDTH     multiplier
//   signed_mode in   1         1: a, b and z are two's complement; 0: unsigned
//   out_valid   out  1         z holds a completed product
//   out_ready   in   1         consumer takes the product
//   z           out  2*WIDTH   product a*b, exact (no overflow possible)
//   busy        out  1         high in ACCUM or RESOLVE
// BEHAVIOUR
//   - Reset (rst high at a clk edge): state=IDLE; out_valid=0; z=0; busy=0;
//     in_ready=1 from the first cycle after reset. rst overrides all other inputs.
//   - States: IDLE -> ACCUM -> RESOLVE -> DONE -> IDLE.
//   - IDLE: in_ready=1. A transfer happens at an edge where in_valid&&in_ready.
//     a, b, signed_mode are registered, the CS sum/carry regs are cleared, the row
//     counter is set to 0, and state goes to ACCUM. Inputs are ignored at all
//     other times, and later input changes do not affect the product in flight.
//   - ACCUM: one row per cycle for WIDTH cycles, row i = a & {WIDTH{b[i]}}
//     shifted left by i. In signed mode, use Baugh-Wooley correction: invert the
//     MSB cross-terms and add the constant 1 at bit WIDTH and bit 2*WIDTH-1.
//     After row WIDTH-1, go to RESOLVE.
//   - RESOLVE: one cycle. z <= (sum + carry) mod 2^(2*WIDTH). out_valid <= 1.
//     Go to DONE.
//   - DONE: z and out_valid hold stable until out_ready is sampled high. At that
//     edge out_valid <= 0 and state goes to IDLE. z keeps its last value.
//     in_ready stays 0 in DONE, so no accept happens in the same cycle.
//   - Latency: out_valid rises exactly WIDTH+1 edges after the accepting edge.
//     Minimum issue interval is WIDTH+3 cycles with out_ready tied high.
//   - Reset in ACCUM, RESOLVE or DONE aborts the operation. No out_valid pulse is
//     produced for it, and the partial result is discarded.
//   - out_ready while out_valid=0 has no effect.
//   - Signed special case: a=b=-2^(WIDTH-1) gives +2^(2*WIDTH-2), exact.
// TESTING
//   1. WIDTH=4, unsigned, a=15 b=15 -> z=8'hE1 exactly 5 edges after accept.
//   2. WIDTH=4, signed: a=4'h8 b=4'h8 -> z=8'h40; a=4'h8 b=4'h7 -> z=8'hC8;
//      a=4'hF b=4'h1 -> z=8'hFF.
//   3. WIDTH=4: all 256 operand pairs in both modes, compared against a
//      behavioural a*b model, with out_ready tied high; issue interval = 7.
//   4. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> z and
//      out_valid stay stable, in_ready=0, new in_valid is ignored; after the
//      out_ready pulse, the next accept happens no earlier than the following edge.
//   5. Assert rst in cycle 2 of ACCUM -> next cycle out_valid=0, busy=0,
//      in_ready=1; the next operation (a=3 b=5) -> z=15 with normal latency.
//   6. WIDTH=8, 10k random operands in both modes, randomised in_valid/out_ready
//      -> every product matches the model, and no product is lost or duplicated.

Source files
------------

// File: rtl/csa_seq_multiplier_if.sv
// Operand/product handshake bundle for csa_seq_multiplier.
// The master drives the operands and out_ready; the multiplier (slave) drives the status and product.
interface csa_seq_multiplier_if #(
    parameter int unsigned WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   z;
    logic                 busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, z, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, z, busy
    );
endinterface

// File: rtl/csa_seq_multiplier.sv
// Iterative carry-save multiplier: one partial-product row per cycle into a sum/carry
// pair, then a single carry-propagate cycle. Signed mode uses Baugh-Wooley rows.
module csa_seq_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    csa_seq_multiplier_if.slave mul
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
    localparam logic [CW-1:0] LAST_ROW = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic            sm_q;
    logic [CW-1:0]   row;
    logic [PW-1:0]   sum;
    logic [PW-1:0]   carry;
    logic [PW-1:0]   z_q;
    logic            out_valid_q;
    logic [WIDTH-1:0] pp;
    logic [PW-1:0]   row_ext;
    logic [PW-1:0]   sum_n;
    logic [PW-1:0]   carry_n;
    logic            accept;

    assign accept        = (state == IDLE) && mul.in_valid;
    assign mul.in_ready  = (state == IDLE);
    assign mul.busy      = (state == ACCUM) || (state == RESOLVE);
    assign mul.out_valid = out_valid_q;
    assign mul.z         = z_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mul.in_valid) state_next = ACCUM;
            ACCUM:   if (row == LAST_ROW) state_next = RESOLVE;
            RESOLVE: state_next = DONE;
            DONE:    if (mul.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Baugh-Wooley: complement the MSB cross-terms; the two correction ones ride on row 0,
    // whose bits never reach position WIDTH or above.
    always_comb begin
        pp = a_q & {WIDTH{b_q[row]}};
        if (sm_q) begin
            if (row == LAST_ROW) begin
                pp[WIDTH-2:0] = ~pp[WIDTH-2:0];
            end else begin
                pp[WIDTH-1] = ~pp[WIDTH-1];
            end
        end
        row_ext = {{WIDTH{1'b0}}, pp} << row;
        if (sm_q && (row == '0)) begin
            row_ext = row_ext | BW_CONST;
        end
        sum_n   = sum ^ carry ^ row_ext;
        carry_n = ((sum & carry) | (sum & row_ext) | (carry & row_ext)) << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            sm_q        <= 1'b0;
            row         <= '0;
            sum         <= '0;
            carry       <= '0;
            z_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= mul.a;
                        b_q   <= mul.b;
                        sm_q  <= mul.signed_mode;
                        row   <= '0;
                        sum   <= '0;
                        carry <= '0;
                    end
                end
                ACCUM: begin
                    sum   <= sum_n;
                    carry <= carry_n;
                    row   <= row + 1'b1;
                end
                RESOLVE: begin
                    z_q         <= sum + carry;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (mul.out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
